// File: rtl/imem_fetch_loader.sv
// ---------------------------------------------------------------------------
// imem_fetch_loader
// Instruction memory with a byte-serial program loader for the 8-bit
// single-cycle CPU. A program is streamed in over a valid/ready interface.
// The block then enters RUN and serves the instruction for the CPU PC with
// zero-cycle latency.
//
// Ports
//   clock         system clock, all state updates on the rising edge
//   clear         synchronous active-high reset
//   load_start    begin a new program load (honoured in IDLE and RUN)
//   load_valid    load_data valid this cycle
//   load_data     instruction byte to store
//   load_last     with load_valid: this byte is the final one
//   load_ready    block accepts a byte this cycle (high only in LOAD)
//   read_address  CPU program counter
//   instruction   combinational fetch result for read_address
//   cpu_run       high only in RUN
//   halted        sticky: PC reached or passed prog_len while running
//   prog_len      number of words loaded (0..DEPTH)
//   state         IDLE=0, LOAD=1, RUN=2 (debug)
// ---------------------------------------------------------------------------
module imem_fetch_loader #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [7:0]  NOP_INSTR = 8'hC0
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       load_start,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    input  logic       load_last,
    output logic       load_ready,
    input  logic [7:0] read_address,
    output logic [7:0] instruction,
    output logic       cpu_run,
    output logic       halted,
    output logic [8:0] prog_len,
    output logic [1:0] state
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [7:0]  LAST_ADDR = 8'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_wptr;
    logic [8:0] r_prog_len;
    logic       r_halted;
    logic       r_load_ready;
    logic       r_cpu_run;
    logic [7:0] r_mem [DEPTH];

    state_t     w_state_nxt;
    logic [7:0] w_wptr_nxt;
    logic [8:0] w_prog_len_nxt;
    logic       w_halted_nxt;
    logic       w_wr_en;
    logic       w_pc_out;

    // PC at or beyond the loaded program; prog_len <= DEPTH also covers addresses >= DEPTH
    assign w_pc_out = ({1'b0, read_address} >= r_prog_len);

    // Zero-latency fetch: the CPU decodes in the same cycle
    assign instruction = w_pc_out ? NOP_INSTR : r_mem[read_address[AW-1:0]];

    // Next-state and register update decisions
    always_comb begin
        w_state_nxt    = r_state;
        w_wptr_nxt     = r_wptr;
        w_prog_len_nxt = r_prog_len;
        w_halted_nxt   = r_halted;
        w_wr_en        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (load_start) begin
                    w_state_nxt    = ST_LOAD;
                    w_wptr_nxt     = 8'd0;
                    w_prog_len_nxt = 9'd0;
                    w_halted_nxt   = 1'b0;
                end
            end
            ST_LOAD: begin
                // load_ready is high throughout LOAD, so load_valid alone marks a transfer
                if (load_valid && r_load_ready) begin
                    w_wr_en        = 1'b1;
                    w_prog_len_nxt = 9'(r_wptr) + 9'd1;
                    if (load_last || (r_wptr == LAST_ADDR)) begin
                        w_state_nxt = ST_RUN;
                    end
                    // Hold the pointer on the final word so it never exceeds DEPTH-1
                    if (r_wptr != LAST_ADDR) begin
                        w_wptr_nxt = r_wptr + 8'd1;
                    end
                end
            end
            ST_RUN: begin
                if (load_start) begin
                    w_state_nxt    = ST_LOAD;
                    w_wptr_nxt     = 8'd0;
                    w_prog_len_nxt = 9'd0;
                    w_halted_nxt   = 1'b0;
                end else if (w_pc_out) begin
                    w_halted_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Control state register; ready/run are registered decodes of the next state
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state      <= ST_IDLE;
            r_wptr       <= 8'd0;
            r_prog_len   <= 9'd0;
            r_halted     <= 1'b0;
            r_load_ready <= 1'b0;
            r_cpu_run    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_wptr       <= w_wptr_nxt;
            r_prog_len   <= w_prog_len_nxt;
            r_halted     <= w_halted_nxt;
            r_load_ready <= (w_state_nxt == ST_LOAD);
            r_cpu_run    <= (w_state_nxt == ST_RUN);
        end
    end

    // Memory array is never reset; prog_len=0 hides stale contents
    always_ff @(posedge clock) begin
        if (w_wr_en && !clear) begin
            r_mem[r_wptr[AW-1:0]] <= load_data;
        end
    end

    assign load_ready = r_load_ready;
    assign cpu_run    = r_cpu_run;
    assign halted     = r_halted;
    assign prog_len   = r_prog_len;
    assign state      = r_state;

endmodule

// File: tb/tb_imem_fetch_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_fetch_loader
// Drives a DEPTH=256 and a DEPTH=4 instance from the same stimulus. Both are
// compared every cycle against a program-level reference model, with
// table-driven vectors, hand sequences and random traffic.
// ---------------------------------------------------------------------------
module tb_imem_fetch_loader;

    logic       clock = 1'b0;
    logic       clear;
    logic       load_start;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic [7:0] read_address;

    logic       rdy_o   [2];
    logic [7:0] instr_o [2];
    logic       run_o   [2];
    logic       halt_o  [2];
    logic [8:0] len_o   [2];
    logic [1:0] st_o    [2];

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    imem_fetch_loader #(.DEPTH(256), .NOP_INSTR(8'hC0)) u_dut256 (
        .clock(clock), .clear(clear), .load_start(load_start),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(rdy_o[0]), .read_address(read_address),
        .instruction(instr_o[0]), .cpu_run(run_o[0]), .halted(halt_o[0]),
        .prog_len(len_o[0]), .state(st_o[0])
    );

    imem_fetch_loader #(.DEPTH(4), .NOP_INSTR(8'hC0)) u_dut4 (
        .clock(clock), .clear(clear), .load_start(load_start),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(rdy_o[1]), .read_address(read_address),
        .instruction(instr_o[1]), .cpu_run(run_o[1]), .halted(halt_o[1]),
        .prog_len(len_o[1]), .state(st_o[1])
    );

    // Reference model: a program is a byte list of length m_len; mode 0/1/2
    int         m_depth [2] = '{256, 4};
    int         m_mode  [2] = '{0, 0};
    int         m_len   [2] = '{0, 0};
    bit         m_halt  [2] = '{1'b0, 1'b0};
    logic [7:0] m_mem   [2][256];

    function automatic logic [7:0] exp_instr(input int k, input logic [7:0] a);
        if (int'(a) < m_len[k]) return m_mem[k][int'(a)];
        return 8'hC0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (clear) begin
                m_mode[k] = 0; m_len[k] = 0; m_halt[k] = 1'b0;
            end else if (m_mode[k] == 0) begin
                if (load_start) begin m_mode[k] = 1; m_len[k] = 0; m_halt[k] = 1'b0; end
            end else if (m_mode[k] == 1) begin
                if (load_valid) begin
                    m_mem[k][m_len[k]] = load_data;
                    m_len[k] = m_len[k] + 1;
                    if (load_last || m_len[k] == m_depth[k]) m_mode[k] = 2;
                end
            end else begin
                if (load_start) begin m_mode[k] = 1; m_len[k] = 0; m_halt[k] = 1'b0; end
                else if (int'(read_address) >= m_len[k]) m_halt[k] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("d%0d.instruction", m_depth[k]), 32'(instr_o[k]), 32'(exp_instr(k, read_address)));
            chk($sformatf("d%0d.state", m_depth[k]),       32'(st_o[k]),    32'(m_mode[k]));
            chk($sformatf("d%0d.prog_len", m_depth[k]),    32'(len_o[k]),   32'(m_len[k]));
            chk($sformatf("d%0d.halted", m_depth[k]),      32'(halt_o[k]),  32'(m_halt[k]));
            chk($sformatf("d%0d.load_ready", m_depth[k]),  32'(rdy_o[k]),   32'(m_mode[k] == 1));
            chk($sformatf("d%0d.cpu_run", m_depth[k]),     32'(run_o[k]),   32'(m_mode[k] == 2));
        end
    endtask

    // One clock edge with the currently driven inputs, then full comparison
    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        check_all();
    endtask

    task automatic drive(input logic c, input logic s, input logic v,
                         input logic [7:0] d, input logic l, input logic [7:0] a);
        clear = c; load_start = s; load_valid = v; load_data = d; load_last = l; read_address = a;
    endtask

    // Combinational fetch probe between edges against a fixed expected word
    task automatic fetch_const(input string name, input int k, input logic [7:0] a, input logic [7:0] exp);
        read_address = a;
        #1;
        chk(name, 32'(instr_o[k]), 32'(exp));
    endtask

    typedef struct packed {
        logic       clr;
        logic       st;
        logic       vld;
        logic [7:0] dat;
        logic       lst;
        logic [7:0] addr;
        logic [1:0] e_state;
        logic [8:0] e_len;
        logic [7:0] e_instr;
        logic       e_halt;
        logic       e_ready;
        logic       e_run;
    } vec_t;

    vec_t vt [12];

    initial begin
        // clr st vld dat lst addr | state len instr halt ready run   (DEPTH=256 instance)
        vt[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 2'd0, 9'd0, 8'hC0, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h05, 2'd0, 9'd0, 8'hC0, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 2'd1, 9'd0, 8'hC0, 1'b0, 1'b1, 1'b0};
        vt[3]  = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 2'd1, 9'd1, 8'h01, 1'b0, 1'b1, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 1'b1, 8'h56, 1'b0, 8'h01, 2'd1, 9'd2, 8'h56, 1'b0, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 1'b1, 8'h9B, 1'b1, 8'h01, 2'd2, 9'd3, 8'h56, 1'b0, 1'b0, 1'b1};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 2'd2, 9'd3, 8'h56, 1'b0, 1'b0, 1'b1};
        vt[7]  = '{1'b0, 1'b0, 1'b1, 8'hEE, 1'b1, 8'h02, 2'd2, 9'd3, 8'h9B, 1'b0, 1'b0, 1'b1};
        vt[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h03, 2'd2, 9'd3, 8'hC0, 1'b1, 1'b0, 1'b1};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h03, 2'd1, 9'd0, 8'hC0, 1'b0, 1'b1, 1'b0};
        vt[10] = '{1'b0, 1'b0, 1'b1, 8'h7F, 1'b1, 8'h00, 2'd2, 9'd1, 8'h7F, 1'b0, 1'b0, 1'b1};
        vt[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 2'd2, 9'd1, 8'h7F, 1'b0, 1'b0, 1'b1};

        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        cycle();

        // Reset, normal load, dropped byte in RUN, halt, reload from RUN
        for (int i = 0; i < 12; i++) begin
            drive(vt[i].clr, vt[i].st, vt[i].vld, vt[i].dat, vt[i].lst, vt[i].addr);
            cycle();
            chk($sformatf("vec%0d.state", i),       32'(st_o[0]),    32'(vt[i].e_state));
            chk($sformatf("vec%0d.prog_len", i),    32'(len_o[0]),   32'(vt[i].e_len));
            chk($sformatf("vec%0d.instruction", i), 32'(instr_o[0]), 32'(vt[i].e_instr));
            chk($sformatf("vec%0d.halted", i),      32'(halt_o[0]),  32'(vt[i].e_halt));
            chk($sformatf("vec%0d.load_ready", i),  32'(rdy_o[0]),   32'(vt[i].e_ready));
            chk($sformatf("vec%0d.cpu_run", i),     32'(run_o[0]),   32'(vt[i].e_run));
        end

        // Stalled load; load_last without load_valid must be ignored
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00); cycle();
        drive(1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 8'h00); cycle();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 8'(i + 8'h30), 1'b1, 8'h00); cycle();
        end
        chk("stall.prog_len", 32'(len_o[0]), 32'd1);
        chk("stall.state", 32'(st_o[0]), 32'd1);
        drive(1'b0, 1'b0, 1'b1, 8'hBB, 1'b1, 8'h00); cycle();
        chk("stall.prog_len_end", 32'(len_o[0]), 32'd2);
        fetch_const("stall.mem0", 0, 8'h00, 8'hAA);
        fetch_const("stall.mem1", 0, 8'h01, 8'hBB);
        fetch_const("stall.mem2", 0, 8'h02, 8'hC0);
        fetch_const("stall.d4_mem1", 1, 8'h01, 8'hBB);

        // Full memory on the DEPTH=4 instance: six bytes, no load_last
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00); cycle();
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00); cycle();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(8'h11 * (i + 1)), 1'b0, 8'h00); cycle();
            if (i == 3) begin
                chk("full.d4_state_after4", 32'(st_o[1]), 32'd2);
                chk("full.d4_len_after4", 32'(len_o[1]), 32'd4);
            end
        end
        chk("full.d4_ready", 32'(rdy_o[1]), 32'd0);
        chk("full.d4_len", 32'(len_o[1]), 32'd4);
        chk("full.d256_len", 32'(len_o[0]), 32'd6);
        fetch_const("full.d4_mem0", 1, 8'h00, 8'h11);
        fetch_const("full.d4_mem3", 1, 8'h03, 8'h44);
        fetch_const("full.d4_addr4", 1, 8'h04, 8'hC0);
        fetch_const("full.d4_addrFF", 1, 8'hFF, 8'hC0);

        // Clear mid-load
        drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00); cycle();
        drive(1'b0, 1'b0, 1'b1, 8'h21, 1'b0, 8'h00); cycle();
        drive(1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 8'h00); cycle();
        drive(1'b1, 1'b0, 1'b1, 8'h23, 1'b0, 8'h00); cycle();
        chk("midclr.state", 32'(st_o[0]), 32'd0);
        chk("midclr.prog_len", 32'(len_o[0]), 32'd0);
        fetch_const("midclr.mem0", 0, 8'h00, 8'hC0);
        fetch_const("midclr.d4_mem0", 1, 8'h00, 8'hC0);

        // Random traffic against the model, with mid-cycle fetch probes
        for (int n = 0; n < 3000; n++) begin
            drive(1'(($urandom % 100) == 0), 1'(($urandom % 40) == 0), 1'(($urandom % 3) != 0),
                  8'($urandom), 1'(($urandom % 6) == 0),
                  (($urandom % 8) == 0) ? 8'($urandom) : 8'($urandom % 12));
            cycle();
            if ((n % 4) == 0) begin
                read_address = 8'($urandom % 10);
                #1;
                chk("rand.fetch_d256", 32'(instr_o[0]), 32'(exp_instr(0, read_address)));
                chk("rand.fetch_d4", 32'(instr_o[1]), 32'(exp_instr(1, read_address)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
